unswitch4_pipe: RTL and testbench

//  Return-path inverse of the 4-lane two-stage 2x2 switch network: takes a 4-lane bundle from the

---
 rtl/switch_pkg.sv | 27 ++
 rtl/unswitch2_stage.sv | 81 ++++++++
 rtl/unswitch4_pipe.sv | 120 ++++++++++++
 tb/tb_unswitch4_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared definitions for the 4-lane 2x2 switch network and its
// return-path inverse.
//   LANES  - lane count of a bundle
//   LANE_W - default lane data width
//   lane_t - one lane of data at the default width
//   pair_t - the two lanes leaving one 2x2 cell
//   swap2  - 2x2 cell: s=0 passes (a,b), s=1 crosses to (b,a); self-inverse
package switch_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    lane_t a;
    lane_t b;
  } pair_t;

  function automatic pair_t swap2(input lane_t a, input lane_t b, input logic s);
    pair_t p;
    p.a = s ? b : a;
    p.b = s ? a : b;
    return p;
  endfunction

endpackage

// File: rtl/unswitch2_stage.sv
// unswitch2_stage: one registered column of two 2x2 cells with valid/ready.
//   Cell X maps (in_d0,in_d1) -> (out_d0,out_d1); cell Y maps
//   (in_d2,in_d3) -> (out_d2,out_d3); both use in_sel.
//   in_sb/out_sb carry SBW bits of sideband alongside the bundle unchanged.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake
//   in_d0..in_d3, in_sel  lane data and cell select for this bundle
//   in_sb                 sideband captured with the bundle
//   out_valid/out_ready   downstream handshake
//   out_d0..out_d3,out_sb registered results
module unswitch2_stage
  import switch_pkg::*;
#(
  parameter int unsigned W   = LANE_W,
  parameter int unsigned SBW = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_d0,
  input  logic [W-1:0]   in_d1,
  input  logic [W-1:0]   in_d2,
  input  logic [W-1:0]   in_d3,
  input  logic           in_sel,
  input  logic [SBW-1:0] in_sb,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_d0,
  output logic [W-1:0]   out_d1,
  output logic [W-1:0]   out_d2,
  output logic [W-1:0]   out_d3,
  output logic [SBW-1:0] out_sb
);

  logic [W-1:0] x0, x1, y0, y1;
  logic         load;

  // The shared cell function is typed at the default lane width; other
  // widths (e.g. data with an appended parity bit) use the same mux inline.
  if (W == LANE_W) begin : g_pkg_swap
    pair_t px, py;
    assign px = swap2(in_d0, in_d1, in_sel);
    assign py = swap2(in_d2, in_d3, in_sel);
    assign x0 = px.a;
    assign x1 = px.b;
    assign y0 = py.a;
    assign y1 = py.b;
  end else begin : g_wide_swap
    assign x0 = in_sel ? in_d1 : in_d0;
    assign x1 = in_sel ? in_d0 : in_d1;
    assign y0 = in_sel ? in_d3 : in_d2;
    assign y1 = in_sel ? in_d2 : in_d3;
  end

  // Load when empty or when the held bundle leaves this same cycle.
  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_d0    <= '0;
      out_d1    <= '0;
      out_d2    <= '0;
      out_d3    <= '0;
      out_sb    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_d0    <= x0;
      out_d1    <= x1;
      out_d2    <= y0;
      out_d3    <= y1;
      out_sb    <= in_sb;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/unswitch4_pipe.sv
// unswitch4_pipe: return-path inverse of the 4-lane two-stage 2x2 switch
// network. Undoes sel1 (stage 1) then sel0 (stage 2), restoring lane order
// in0..in3 from switched lanes r0..r3. Two registered stages, one
// bundle-wide valid/ready handshake, 2-cycle latency, 1 bundle/cycle.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   s_valid/s_ready      input bundle handshake
//   s_data0..s_data3     switched-side lanes r0..r3
//   s_sel0, s_sel1       forward selects used for this bundle
//   m_valid/m_ready      output bundle handshake
//   m_data0..m_data3     restored lanes in0..in3
// Build option UNSWITCH4_PARITY_EN adds:
//   s_par[3:0]           even parity per input lane
//   m_perr               any output lane has odd parity (with m_valid)
module unswitch4_pipe
  import switch_pkg::*;
#(
  parameter int unsigned W = LANE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data0,
  input  logic [W-1:0] s_data1,
  input  logic [W-1:0] s_data2,
  input  logic [W-1:0] s_data3,
  input  logic         s_sel0,
  input  logic         s_sel1,
`ifdef UNSWITCH4_PARITY_EN
  input  logic [LANES-1:0] s_par,
  output logic             m_perr,
`endif
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data0,
  output logic [W-1:0] m_data1,
  output logic [W-1:0] m_data2,
  output logic [W-1:0] m_data3
);

  // Parity travels as an extra top bit of each lane so the cells permute it
  // exactly like the data it protects.
`ifdef UNSWITCH4_PARITY_EN
  localparam int unsigned LW = W + 1;
`else
  localparam int unsigned LW = W;
`endif

  logic [LW-1:0] l0, l1, l2, l3;
  logic [LW-1:0] a, b, c, d;
  logic [LW-1:0] o0, o1, o2, o3;
  logic          v1, rdy2, sel0_q;
  logic          sb2_unused;

`ifdef UNSWITCH4_PARITY_EN
  assign l0 = {s_par[0], s_data0};
  assign l1 = {s_par[1], s_data1};
  assign l2 = {s_par[2], s_data2};
  assign l3 = {s_par[3], s_data3};
  assign m_data0 = o0[W-1:0];
  assign m_data1 = o1[W-1:0];
  assign m_data2 = o2[W-1:0];
  assign m_data3 = o3[W-1:0];
  // Registered lanes hold during a stall, so the flag holds with them.
  assign m_perr  = m_valid && ((^o0) || (^o1) || (^o2) || (^o3));
`else
  assign l0 = s_data0;
  assign l1 = s_data1;
  assign l2 = s_data2;
  assign l3 = s_data3;
  assign m_data0 = o0;
  assign m_data1 = o1;
  assign m_data2 = o2;
  assign m_data3 = o3;
`endif

  // Stage 1 undoes sel1: (A,C)=swap(r0,r1), (B,D)=swap(r2,r3); sel0 rides along.
  unswitch2_stage #(.W(LW), .SBW(1)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_d0     (l0),
    .in_d1     (l1),
    .in_d2     (l2),
    .in_d3     (l3),
    .in_sel    (s_sel1),
    .in_sb     (s_sel0),
    .out_valid (v1),
    .out_ready (rdy2),
    .out_d0    (a),
    .out_d1    (c),
    .out_d2    (b),
    .out_d3    (d),
    .out_sb    (sel0_q)
  );

  // Stage 2 undoes sel0: (in0,in2)=swap(A,B), (in1,in3)=swap(C,D).
  unswitch2_stage #(.W(LW), .SBW(1)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .in_ready  (rdy2),
    .in_d0     (a),
    .in_d1     (b),
    .in_d2     (c),
    .in_d3     (d),
    .in_sel    (sel0_q),
    .in_sb     (1'b0),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_d0    (o0),
    .out_d1    (o2),
    .out_d2    (o1),
    .out_d3    (o3),
    .out_sb    (sb2_unused)
  );

endmodule

// File: tb/tb_unswitch4_pipe.sv
module tb_unswitch4_pipe;

  localparam int unsigned W = 8;

  logic         clk, rst;
  logic         s_valid, s_ready;
  logic [W-1:0] s_data0, s_data1, s_data2, s_data3;
  logic         s_sel0, s_sel1;
  logic         m_valid, m_ready;
  logic [W-1:0] m_data0, m_data1, m_data2, m_data3;
`ifdef UNSWITCH4_PARITY_EN
  logic [3:0]   s_par;
  logic         m_perr;
  logic [3:0]   par_flip;
`endif

  unswitch4_pipe #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data0 (s_data0),
    .s_data1 (s_data1),
    .s_data2 (s_data2),
    .s_data3 (s_data3),
    .s_sel0  (s_sel0),
    .s_sel1  (s_sel1),
`ifdef UNSWITCH4_PARITY_EN
    .s_par   (s_par),
    .m_perr  (m_perr),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data0 (m_data0),
    .m_data1 (m_data1),
    .m_data2 (m_data2),
    .m_data3 (m_data3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        perr;
    logic [31:0] d;    // {in3,in2,in1,in0}
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned popped  = 0;
  bit          rt_done;

  logic        stalled = 1'b0;
  logic [31:0] held;
  logic        held_perr;

  // Forward switch network: stage 1 on sel0, stage 2 on sel1.
  function automatic logic [31:0] fwd(input logic [31:0] x, input logic s0, input logic s1);
    logic [7:0] i0, i1, i2, i3, a, b, c, d, r0, r1, r2, r3;
    {i3, i2, i1, i0} = x;
    a  = s0 ? i2 : i0;  b  = s0 ? i0 : i2;
    c  = s0 ? i3 : i1;  d  = s0 ? i1 : i3;
    r0 = s1 ? c : a;    r1 = s1 ? a : c;
    r2 = s1 ? d : b;    r3 = s1 ? b : d;
    return {r3, r2, r1, r0};
  endfunction

  // Scoreboard checker: pops one expected bundle per output handshake and
  // checks that stalled outputs hold.
  always @(negedge clk) begin
    exp_t e;
    logic cur_perr;
`ifdef UNSWITCH4_PARITY_EN
    cur_perr = m_perr;
`else
    cur_perr = 1'b0;
`endif
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && m_valid) begin
        vectors++;
        if ({m_data3, m_data2, m_data1, m_data0, cur_perr} !== {held, held_perr}) begin
          errors++;
          $display("FAIL stall_hold: m_data=%h perr=%b, held was %h perr=%b",
                   {m_data3, m_data2, m_data1, m_data0}, cur_perr, held, held_perr);
        end
      end
      if (m_valid && m_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: m_data=%h, no bundle expected",
                   {m_data3, m_data2, m_data1, m_data0});
        end else begin
          e = sb.pop_front();
          popped++;
          if ({m_data3, m_data2, m_data1, m_data0} !== e.d) begin
            errors++;
            $display("FAIL bundle_data: m_data=%h expected %h",
                     {m_data3, m_data2, m_data1, m_data0}, e.d);
          end
`ifdef UNSWITCH4_PARITY_EN
          vectors++;
          if (m_perr !== e.perr) begin
            errors++;
            $display("FAIL bundle_perr: m_perr=%b expected %b (data %h)", m_perr, e.perr, e.d);
          end
`endif
        end
      end
      stalled   = m_valid && !m_ready;
      held      = {m_data3, m_data2, m_data1, m_data0};
      held_perr = cur_perr;
    end
  end

  // Presents one bundle; the expectation is queued once it is accepted.
  task automatic send(input logic [31:0] r, input logic sel0, input logic sel1,
                      input logic [31:0] e, input logic eperr);
    int unsigned n;
    logic        ok;
    exp_t        x;
    n = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    {s_data3, s_data2, s_data1, s_data0} = r;
    s_sel0 = sel0;
    s_sel1 = sel1;
`ifdef UNSWITCH4_PARITY_EN
    s_par = {^r[31:24], ^r[23:16], ^r[15:8], ^r[7:0]} ^ par_flip;
`endif
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
    end else begin
      x.d = e;
      x.perr = eperr;
      sb.push_back(x);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bundles outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (m_valid !== 1'b0 || {m_data3, m_data2, m_data1, m_data0} !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: m_valid=%b m_data=%h, required 0 and 0",
               m_valid, {m_data3, m_data2, m_data1, m_data0});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b m_valid=%b, required 1 and 0", s_ready, m_valid);
    end
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    send({8'h13, 8'h12, 8'h11, 8'h10}, 1'b0, 1'b0, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b0);
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: m_valid=%b one cycle after accept, required 0", m_valid);
    end
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_2cyc: m_valid=%b two cycles after accept, required 1", m_valid);
    end
    drain();
  endtask

  task automatic test_perms();
    logic [31:0] r;
    logic [31:0] exp_tab [4];
    r = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    exp_tab[0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0};  // sel1=0 sel0=0
    exp_tab[1] = {8'hA1, 8'hA0, 8'hA3, 8'hA2};  // sel1=0 sel0=1
    exp_tab[2] = {8'hA2, 8'hA3, 8'hA0, 8'hA1};  // sel1=1 sel0=0
    exp_tab[3] = {8'hA0, 8'hA1, 8'hA2, 8'hA3};  // sel1=1 sel0=1
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      send(r, k[0], k[1], exp_tab[k], 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int unsigned base;
    base = popped;
    m_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] o;
          logic        s0, s1;
          o  = $urandom;
          s0 = 1'($urandom_range(0, 1));
          s1 = 1'($urandom_range(0, 1));
          send(fwd(o, s0, s1), s0, s1, o, 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_backpressure: s_ready=%b m_valid=%b, required 0 and 1",
                   s_ready, m_valid);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();
    vectors++;
    if (popped - base != 8) begin
      errors++;
      $display("FAIL b2b_count: delivered %0d bundles, required 8", popped - base);
    end
  endtask

  task automatic test_round_trip();
    int unsigned base;
    base = popped;
    rt_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] o;
          logic        s0, s1;
          o  = $urandom;
          s0 = 1'($urandom_range(0, 1));
          s1 = 1'($urandom_range(0, 1));
          send(fwd(o, s0, s1), s0, s1, o, 1'b0);
        end
        rt_done = 1'b1;
      end
      begin
        while (!rt_done) begin
          @(posedge clk);
          #1 m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    drain();
    vectors++;
    if (popped - base != 1000) begin
      errors++;
      $display("FAIL round_trip_count: delivered %0d bundles, required 1000", popped - base);
    end
  endtask

  task automatic test_reset_inflight();
    int unsigned base;
    m_ready = 1'b0;
    send(fwd(32'h11223344, 1'b1, 1'b0), 1'b1, 1'b0, 32'h11223344, 1'b0);
    send(fwd(32'h55667788, 1'b0, 1'b1), 1'b0, 1'b1, 32'h55667788, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: m_valid=%b right after rst, required 0", m_valid);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: s_ready=%b one cycle after release, required 1", s_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_flush: m_valid=%b %0d cycles after release, required 0", m_valid, i);
      end
    end
    @(posedge clk);
    #1;
    base = popped;
    send(fwd(32'hC0FFEE42, 1'b1, 1'b1), 1'b1, 1'b1, 32'hC0FFEE42, 1'b0);
    drain();
    vectors++;
    if (popped - base != 1) begin
      errors++;
      $display("FAIL reset_resume: delivered %0d bundles after release, required 1", popped - base);
    end
  endtask

`ifdef UNSWITCH4_PARITY_EN
  task automatic test_parity();
    logic [31:0] o;
    o = {8'h3C, 8'h5A, 8'h81, 8'h07};
    m_ready = 1'b1;
    par_flip = 4'b0000;
    send(fwd(o, 1'b1, 1'b1), 1'b1, 1'b1, o, 1'b0);
    par_flip = 4'b0100;
    send(fwd(o, 1'b1, 1'b1), 1'b1, 1'b1, o, 1'b1);
    par_flip = 4'b0000;
    send(fwd(o, 1'b1, 1'b1), 1'b1, 1'b1, o, 1'b0);
    drain();
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    s_data0 = '0;
    s_data1 = '0;
    s_data2 = '0;
    s_data3 = '0;
    s_sel0 = 1'b0;
    s_sel1 = 1'b0;
`ifdef UNSWITCH4_PARITY_EN
    s_par = '0;
    par_flip = '0;
`endif
    test_reset();
    test_basic();
    test_perms();
    test_back_to_back();
    test_round_trip();
    test_reset_inflight();
`ifdef UNSWITCH4_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
